// File: rtl/multi_cycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I controller:
// opcodes, state encoding, datapath select encodings.
package cpu_defs;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EX   = 4'd2,
        S_MEM  = 4'd3,
        S_WB   = 4'd4,
        S_PC4  = 4'd5,
        S_HALT = 4'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BR,
        C_JAL, C_JALR, C_ECALL, C_BAD
    } op_class_t;

    localparam logic [1:0] SRCB_B   = 2'd0;
    localparam logic [1:0] SRCB_4   = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_BR  = 2'd1;
    localparam logic [1:0] ALU_FN  = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_ALU    = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op_sel;
        logic [1:0] wb_sel;
        logic       reg_write;
    } ctrl_t;

    function automatic op_class_t classify(input logic [6:0] op);
        op_class_t c;
        unique case (op)
            OP_R:      c = C_R;
            OP_I:      c = C_I;
            OP_LOAD:   c = C_LOAD;
            OP_STORE:  c = C_STORE;
            OP_BRANCH: c = C_BR;
            OP_JAL:    c = C_JAL;
            OP_JALR:   c = C_JALR;
            OP_SYSTEM: c = C_ECALL;
            default:   c = C_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_control_fsm_mem_wait_counter.sv
// Cycle counter for variable-latency memory accesses.
// Counts while enabled; clear wins over enable.
module mem_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I datapath.
// Steps IF/ID/EX/MEM/WB with stretched memory phases and ecall halt.
module multi_cycle_control_fsm
    import cpu_defs::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_cond,
    output logic       pc_write,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op_sel,
    output logic [1:0] wb_sel,
    output logic       reg_write,
    output logic       is_halted
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY - 1);

    state_t           state;
    logic             halted;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             mem_phase;
    op_class_t        cls;
    ctrl_t            c;

    assign cls       = classify(opcode);
    assign mem_phase = (state == S_IF) || (state == S_MEM);
    assign last      = (cnt == LAST);

    mem_wait_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (mem_phase),
        .clear (last || !mem_phase),
        .cnt   (cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IF;
            halted <= 1'b0;
        end else begin
            unique case (state)
                S_IF: if (last) state <= S_ID;
                S_ID: begin
                    if (cls == C_ECALL && halt_cond) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (cls == C_ECALL || cls == C_BAD) begin
                        state <= S_PC4;
                    end else begin
                        state <= S_EX;
                    end
                end
                S_EX: begin
                    unique case (cls)
                        C_R, C_I, C_JALR: state <= S_WB;
                        C_LOAD, C_STORE:  state <= S_MEM;
                        C_BR:    state <= bcond ? S_IF : S_PC4;
                        C_JAL:   state <= S_IF;
                        default: state <= S_PC4;
                    endcase
                end
                S_MEM: if (last) state <= (cls == C_LOAD) ? S_WB : S_IF;
                S_WB, S_PC4: state <= S_IF;
                S_HALT: state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end

    // Reset low forces every control line inactive, aborting any access.
    always_comb begin
        c = '0;
        if (reset) begin
            unique case (state)
                S_IF: begin
                    c.mem_read = 1'b1;
                    c.ir_write = last;
                end
                S_ID: c.alu_src_b = SRCB_IMM;
                S_EX: begin
                    unique case (cls)
                        C_R: begin
                            c.alu_src_a  = 1'b1;
                            c.alu_op_sel = ALU_FN;
                        end
                        C_I: begin
                            c.alu_src_a  = 1'b1;
                            c.alu_src_b  = SRCB_IMM;
                            c.alu_op_sel = ALU_FN;
                        end
                        C_LOAD, C_STORE, C_JALR: begin
                            c.alu_src_a = 1'b1;
                            c.alu_src_b = SRCB_IMM;
                        end
                        C_BR: begin
                            c.alu_src_a  = 1'b1;
                            c.alu_op_sel = ALU_BR;
                            c.pc_source  = 1'b1;
                            c.pc_write   = bcond;
                        end
                        C_JAL: begin
                            c.alu_src_b = SRCB_4;
                            c.reg_write = 1'b1;
                            c.wb_sel    = WB_ALU;
                            c.pc_source = 1'b1;
                            c.pc_write  = 1'b1;
                        end
                        default: c = '0;
                    endcase
                end
                S_MEM: begin
                    c.i_or_d = 1'b1;
                    if (cls == C_LOAD) begin
                        c.mem_read  = 1'b1;
                        c.mdr_write = last;
                    end else if (last) begin
                        c.mem_write = 1'b1;
                        c.alu_src_b = SRCB_4;
                        c.pc_write  = 1'b1;
                    end
                end
                S_WB: begin
                    c.alu_src_b = SRCB_4;
                    c.reg_write = 1'b1;
                    c.pc_write  = 1'b1;
                    if (cls == C_LOAD) begin
                        c.wb_sel = WB_MDR;
                    end else if (cls == C_JALR) begin
                        c.wb_sel    = WB_ALU;
                        c.pc_source = 1'b1;
                    end
                end
                S_PC4: begin
                    c.alu_src_b = SRCB_4;
                    c.pc_write  = 1'b1;
                end
                default: c = '0;
            endcase
        end
    end

    assign pc_write   = c.pc_write;
    assign pc_source  = c.pc_source;
    assign i_or_d     = c.i_or_d;
    assign mem_read   = c.mem_read;
    assign mem_write  = c.mem_write;
    assign ir_write   = c.ir_write;
    assign mdr_write  = c.mdr_write;
    assign alu_src_a  = c.alu_src_a;
    assign alu_src_b  = c.alu_src_b;
    assign alu_op_sel = c.alu_op_sel;
    assign wb_sel     = c.wb_sel;
    assign reg_write  = c.reg_write;
    assign is_halted  = halted && reset;

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Directed vector bench for multi_cycle_control_fsm at
// memory latencies 1, 2 and 3 (one instance each, shared inputs).
module tb_multi_cycle_control_fsm;

    localparam logic [15:0] PCW  = 16'h8000;
    localparam logic [15:0] PCS  = 16'h4000;
    localparam logic [15:0] IOD  = 16'h2000;
    localparam logic [15:0] MR   = 16'h1000;
    localparam logic [15:0] MW   = 16'h0800;
    localparam logic [15:0] IRW  = 16'h0400;
    localparam logic [15:0] MDRW = 16'h0200;
    localparam logic [15:0] SA   = 16'h0100;
    localparam logic [15:0] SB2  = 16'h0080;
    localparam logic [15:0] SB1  = 16'h0040;
    localparam logic [15:0] OP2  = 16'h0020;
    localparam logic [15:0] OP1  = 16'h0010;
    localparam logic [15:0] WB2  = 16'h0008;
    localparam logic [15:0] WB1  = 16'h0004;
    localparam logic [15:0] RW   = 16'h0002;
    localparam logic [15:0] HLT  = 16'h0001;

    localparam logic [6:0] ADD  = 7'h33;
    localparam logic [6:0] ADDI = 7'h13;
    localparam logic [6:0] LW   = 7'h03;
    localparam logic [6:0] SW   = 7'h23;
    localparam logic [6:0] BEQ  = 7'h63;
    localparam logic [6:0] JAL  = 7'h6F;
    localparam logic [6:0] JALR = 7'h67;
    localparam logic [6:0] ECL  = 7'h73;
    localparam logic [6:0] BAD  = 7'h7F;

    typedef struct {
        int         lat;
        logic       rst;
        logic [6:0] op;
        logic       bc;
        logic       hc;
        logic [15:0] exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       bcond;
    logic       halt_cond;

    logic       pcw [3];
    logic       pcs [3];
    logic       iod [3];
    logic       mr  [3];
    logic       mw  [3];
    logic       irw [3];
    logic       mdrw[3];
    logic       sa  [3];
    logic [1:0] sb  [3];
    logic [1:0] ops [3];
    logic [1:0] wbs [3];
    logic       rw  [3];
    logic       hlt [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multi_cycle_control_fsm #(
            .MEM_LATENCY(g + 1),
            .CNT_W(4)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .opcode     (opcode),
            .bcond      (bcond),
            .halt_cond  (halt_cond),
            .pc_write   (pcw[g]),
            .pc_source  (pcs[g]),
            .i_or_d     (iod[g]),
            .mem_read   (mr[g]),
            .mem_write  (mw[g]),
            .ir_write   (irw[g]),
            .mdr_write  (mdrw[g]),
            .alu_src_a  (sa[g]),
            .alu_src_b  (sb[g]),
            .alu_op_sel (ops[g]),
            .wb_sel     (wbs[g]),
            .reg_write  (rw[g]),
            .is_halted  (hlt[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    vec_t tbl[$];
    int   nvec;
    int   nfail;

    function automatic void add(input int lat, input logic rst,
                                input logic [6:0] op, input logic bc,
                                input logic hc, input logic [15:0] exp);
        vec_t v;
        v = '{lat: lat, rst: rst, op: op, bc: bc, hc: hc, exp: exp};
        tbl.push_back(v);
    endfunction

    function automatic logic [15:0] pack(input int k);
        return {pcw[k], pcs[k], iod[k], mr[k], mw[k], irw[k], mdrw[k],
                sa[k], sb[k], ops[k], wbs[k], rw[k], hlt[k]};
    endfunction

    task automatic check(input int lat, input logic [15:0] exp,
                         input string nm, input int idx);
        logic [15:0] got;
        got = pack(lat - 1);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s #%0d L=%0d: got %h, want %h",
                     nm, idx, lat, got, exp);
        end
    endtask

    initial begin
        nvec      = 0;
        nfail     = 0;
        reset     = 1'b0;
        opcode    = ADD;
        bcond     = 1'b0;
        halt_cond = 1'b0;

        // reset held two cycles, then add x3,x1,x2
        add(1, 0, ADD, 0, 0, 16'h0);
        add(1, 0, ADD, 0, 0, 16'h0);
        add(1, 1, ADD, 0, 0, MR | IRW);
        add(1, 1, ADD, 0, 0, SB2);
        add(1, 1, ADD, 0, 0, SA | OP2);
        add(1, 1, ADD, 0, 0, SB1 | RW | PCW);
        add(1, 1, ADD, 0, 0, MR | IRW);
        // addi
        add(1, 0, ADDI, 0, 0, 16'h0);
        add(1, 1, ADDI, 0, 0, MR | IRW);
        add(1, 1, ADDI, 0, 0, SB2);
        add(1, 1, ADDI, 0, 0, SA | SB2 | OP2);
        add(1, 1, ADDI, 0, 0, SB1 | RW | PCW);
        // lw, latency 3
        add(3, 0, LW, 0, 0, 16'h0);
        add(3, 1, LW, 0, 0, MR);
        add(3, 1, LW, 0, 0, MR);
        add(3, 1, LW, 0, 0, MR | IRW);
        add(3, 1, LW, 0, 0, SB2);
        add(3, 1, LW, 0, 0, SA | SB2);
        add(3, 1, LW, 0, 0, IOD | MR);
        add(3, 1, LW, 0, 0, IOD | MR);
        add(3, 1, LW, 0, 0, IOD | MR | MDRW);
        add(3, 1, LW, 0, 0, SB1 | RW | WB1 | PCW);
        add(3, 1, LW, 0, 0, MR);
        // beq taken then not taken
        add(1, 0, BEQ, 1, 0, 16'h0);
        add(1, 1, BEQ, 1, 0, MR | IRW);
        add(1, 1, BEQ, 1, 0, SB2);
        add(1, 1, BEQ, 1, 0, SA | OP1 | PCS | PCW);
        add(1, 1, BEQ, 0, 0, MR | IRW);
        add(1, 1, BEQ, 0, 0, SB2);
        add(1, 1, BEQ, 0, 0, SA | OP1 | PCS);
        add(1, 1, BEQ, 0, 0, SB1 | PCW);
        add(1, 1, BEQ, 0, 0, MR | IRW);
        // jal
        add(1, 0, JAL, 0, 0, 16'h0);
        add(1, 1, JAL, 0, 0, MR | IRW);
        add(1, 1, JAL, 0, 0, SB2);
        add(1, 1, JAL, 0, 0, SB1 | RW | WB2 | PCS | PCW);
        add(1, 1, JAL, 0, 0, MR | IRW);
        // jalr
        add(1, 0, JALR, 0, 0, 16'h0);
        add(1, 1, JALR, 0, 0, MR | IRW);
        add(1, 1, JALR, 0, 0, SB2);
        add(1, 1, JALR, 0, 0, SA | SB2);
        add(1, 1, JALR, 0, 0, SB1 | RW | WB2 | PCS | PCW);
        add(1, 1, JALR, 0, 0, MR | IRW);
        // sw, latency 1
        add(1, 0, SW, 0, 0, 16'h0);
        add(1, 1, SW, 0, 0, MR | IRW);
        add(1, 1, SW, 0, 0, SB2);
        add(1, 1, SW, 0, 0, SA | SB2);
        add(1, 1, SW, 0, 0, IOD | MW | SB1 | PCW);
        add(1, 1, SW, 0, 0, MR | IRW);
        // unknown opcode behaves as nop
        add(1, 0, BAD, 0, 0, 16'h0);
        add(1, 1, BAD, 0, 0, MR | IRW);
        add(1, 1, BAD, 0, 0, SB2);
        add(1, 1, BAD, 0, 0, SB1 | PCW);
        add(1, 1, BAD, 0, 0, MR | IRW);
        // sw latency 2 with reset on first MEM cycle
        add(2, 0, SW, 0, 0, 16'h0);
        add(2, 1, SW, 0, 0, MR);
        add(2, 1, SW, 0, 0, MR | IRW);
        add(2, 1, SW, 0, 0, SB2);
        add(2, 1, SW, 0, 0, SA | SB2);
        add(2, 0, SW, 0, 0, 16'h0);
        add(2, 1, SW, 0, 0, MR);
        add(2, 1, SW, 0, 0, MR | IRW);
        // ecall: no halt, then halt
        add(1, 0, ECL, 0, 0, 16'h0);
        add(1, 1, ECL, 0, 0, MR | IRW);
        add(1, 1, ECL, 0, 0, SB2);
        add(1, 1, ECL, 0, 0, SB1 | PCW);
        add(1, 1, ECL, 0, 0, MR | IRW);
        add(1, 1, ECL, 0, 1, SB2);

        foreach (tbl[i]) begin
            @(negedge clk);
            reset     = tbl[i].rst;
            opcode    = tbl[i].op;
            bcond     = tbl[i].bc;
            halt_cond = tbl[i].hc;
            #1;
            check(tbl[i].lat, tbl[i].exp, "vec", i);
        end

        // HALT must absorb whatever the inputs do
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            reset     = 1'b1;
            opcode    = (i % 2 == 0) ? ADD : SW;
            bcond     = 1'b1;
            halt_cond = (i % 3 == 0);
            #1;
            check(1, HLT, "halt_hold", i);
        end

        // reset releases HALT
        @(negedge clk);
        reset = 1'b0;
        #1;
        check(1, 16'h0, "halt_reset", 0);
        @(negedge clk);
        reset  = 1'b1;
        opcode = ADD;
        #1;
        check(1, MR | IRW, "halt_exit", 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
